// File: rtl/shared_byte_pkg.sv
// Shared types and the round-robin pick function for the byte arbiter family.
// rr_pick works on a maximum-width request vector so every variant can reuse it.
package shared_byte_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int MAX_PROD   = 8;
    localparam int MAX_ID_W   = 3;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // First set request searching cyclically from last+1; only the low num bits are live.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_PROD-1:0] req,
        input logic [MAX_ID_W-1:0] last,
        input int                  num
    );
        rr_pick_t            res;
        logic [MAX_ID_W-1:0] cand;
        res = '0;
        for (int k = 1; k <= MAX_PROD; k++) begin
            if (k <= num) begin
                cand = MAX_ID_W'((int'(last) + k) % num);
                if (!res.found && req[cand]) begin
                    res.found = 1'b1;
                    res.idx   = cand;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational rotate-priority picker: the first request after 'last' wins.
// Kept separate so multi-consumer variants can instantiate several of them.
module rr_select
    import shared_byte_pkg::*;
#(
    parameter  int NUM_PROD = 3,
    localparam int ID_W     = $clog2(NUM_PROD)
) (
    input  logic [NUM_PROD-1:0] req,
    input  logic [ID_W-1:0]     last,
    output logic                found,
    output logic [ID_W-1:0]     idx
);

    logic [MAX_PROD-1:0] req_ext;
    logic [MAX_ID_W-1:0] last_ext;
    rr_pick_t            pick;
    logic                pick_unused;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_PROD-1:0]  = req;
        last_ext               = '0;
        last_ext[ID_W-1:0]     = last;
        pick                   = rr_pick(req_ext, last_ext, NUM_PROD);
        found                  = pick.found;
        idx                    = pick.idx[ID_W-1:0];
    end

    // Upper index bits are always zero when NUM_PROD is below the maximum.
    assign pick_unused = ^pick.idx;

endmodule

// File: rtl/shared_byte_arbiter.sv
// Shares one byte channel between NUM_PROD req/ack producers and one valid/ready consumer.
// A single output register is refilled on the same edge the consumer drains it.
module shared_byte_arbiter
    import shared_byte_pkg::*;
#(
    parameter  int NUM_PROD = 3,
    parameter  int DATA_W   = DATA_W_DEF,
    localparam int ID_W     = $clog2(NUM_PROD)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_PROD-1:0]        prod_req,
    input  logic [NUM_PROD*DATA_W-1:0] prod_data,
    output logic [NUM_PROD-1:0]        prod_ack,
    output logic                       cons_valid,
    output logic [DATA_W-1:0]          cons_data,
    input  logic                       cons_ready,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [DATA_W-1:0]   cons_data_q, cons_data_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                cons_valid_q, cons_valid_d;
    logic [NUM_PROD-1:0] prod_ack_q, prod_ack_d;

    logic [NUM_PROD-1:0] eligible;
    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic                capture;

    // A producer is masked while its ack is high so its still-raised request is not taken twice.
    assign eligible = prod_req & ~prod_ack_q;

    rr_select #(
        .NUM_PROD (NUM_PROD)
    ) u_rr_select (
        .req   (eligible),
        .last  (last_q),
        .found (win_found),
        .idx   (win_idx)
    );

    assign capture = win_found && ((state_q == EMPTY) || cons_ready);

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cons_data_d  = cons_data_q;
        grant_id_d   = grant_id_q;
        cons_valid_d = cons_valid_q;
        prod_ack_d   = '0;
        if (capture) begin
            cons_data_d         = prod_data[int'(win_idx)*DATA_W +: DATA_W];
            grant_id_d          = win_idx;
            last_d              = win_idx;
            cons_valid_d        = 1'b1;
            state_d             = FULL;
            prod_ack_d[win_idx] = 1'b1;
        end else if ((state_q == FULL) && cons_ready) begin
            cons_valid_d = 1'b0;
            state_d      = EMPTY;
        end
    end

    // Pointer resets to the top index so producer 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            last_q       <= ID_W'(NUM_PROD - 1);
            cons_data_q  <= '0;
            grant_id_q   <= '0;
            cons_valid_q <= 1'b0;
            prod_ack_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cons_data_q  <= cons_data_d;
            grant_id_q   <= grant_id_d;
            cons_valid_q <= cons_valid_d;
            prod_ack_q   <= prod_ack_d;
        end
    end

    assign prod_ack   = prod_ack_q;
    assign cons_valid = cons_valid_q;
    assign cons_data  = cons_data_q;
    assign grant_id   = grant_id_q;
    assign busy       = cons_valid_q | (|eligible);

endmodule

// File: tb/tb_shared_byte_arbiter.sv
// Self-checking bench: directed handshake scenarios plus randomized traffic,
// all compared every cycle against a behavioural round-robin model.
module tb_shared_byte_arbiter;

    localparam int NP = 3;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NP-1:0]     prod_req = '0;
    logic [NP*DW-1:0]  prod_data = '0;
    logic              cons_ready = 1'b0;
    logic [NP-1:0]     prod_ack;
    logic              cons_valid;
    logic [DW-1:0]     cons_data;
    logic [IW-1:0]     grant_id;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_grant;
    int            m_ack;
    int            m_last;
    int            wait_cnt [NP];
    int            mw, mbest, mdist;
    logic [NP-1:0] cmp_av;

    // Random-phase stimulus state
    logic [NP-1:0]    rq;
    logic [NP*DW-1:0] dt;

    shared_byte_arbiter #(
        .NUM_PROD (NP),
        .DATA_W   (DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .prod_req   (prod_req),
        .prod_data  (prod_data),
        .prod_ack   (prod_ack),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] ackv();
        logic [NP-1:0] v;
        v = '0;
        if (m_ack >= 0) v[m_ack] = 1'b1;
        return v;
    endfunction

    // Model: winner is the requesting, unmasked producer at the smallest cyclic distance after last.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_grant = 0;
            m_ack   = -1;
            m_last  = NP - 1;
            for (int i = 0; i < NP; i++) wait_cnt[i] = 0;
        end else begin
            mw    = -1;
            mbest = NP;
            for (int i = 0; i < NP; i++) begin
                if (prod_req[i] && (i != m_ack)) begin
                    mdist = (i - m_last - 1 + NP) % NP;
                    if (mdist < mbest) begin
                        mbest = mdist;
                        mw    = i;
                    end
                end
            end
            if ((mw >= 0) && (!m_valid || cons_ready)) begin
                chk($sformatf("fair_wait_p%0d", mw), 32'(wait_cnt[mw] <= NP - 1), 32'd1);
                for (int i = 0; i < NP; i++)
                    if ((i != mw) && prod_req[i] && (i != m_ack)) wait_cnt[i]++;
                wait_cnt[mw] = 0;
                m_data  = prod_data[mw*DW +: DW];
                m_grant = mw;
                m_last  = mw;
                m_valid = 1'b1;
                m_ack   = mw;
            end else begin
                m_ack = -1;
                if (m_valid && cons_ready) m_valid = 1'b0;
            end
            for (int i = 0; i < NP; i++)
                if (!prod_req[i]) wait_cnt[i] = 0;
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        cmp_av = ackv();
        chk("cons_valid", 32'(cons_valid), 32'(m_valid));
        chk("cons_data", 32'(cons_data), 32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
        chk("prod_ack", 32'(prod_ack), 32'(cmp_av));
        chk("busy", 32'(busy), 32'(m_valid || (|(prod_req & ~cmp_av))));
        chk("ack_onehot", 32'($onehot0(prod_ack)), 32'd1);
    end

    task automatic applyStimulus(input logic [NP-1:0] req, input logic [NP*DW-1:0] data,
                                 input logic ready);
        #1;
        prod_req   = req;
        prod_data  = data;
        cons_ready = ready;
    endtask

    task automatic checkNow(input string tag, input logic v, input logic [DW-1:0] d,
                            input logic [IW-1:0] g, input logic [NP-1:0] a, input logic b);
        chk({tag, "_valid"}, 32'(cons_valid), 32'(v));
        chk({tag, "_data"}, 32'(cons_data), 32'(d));
        chk({tag, "_grant"}, 32'(grant_id), 32'(g));
        chk({tag, "_ack"}, 32'(prod_ack), 32'(a));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_model"}, 32'({m_valid, m_data, m_grant[IW-1:0], ackv()}), 32'({v, d, g, a}));
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [DW-1:0] d,
                               input logic [IW-1:0] g, input logic [NP-1:0] a, input logic b);
        @(negedge clk);
        checkNow(tag, v, d, g, a, b);
    endtask

    task automatic doReset();
        #1;
        reset_n    = 1'b0;
        prod_req   = '0;
        prod_data  = '0;
        cons_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] t2_data [3];
        t2_data[0] = 8'h10;
        t2_data[1] = 8'h20;
        t2_data[2] = 8'h30;

        // Single producer: capture, masked ack cycle, then the next byte
        doReset();
        checkNow("rst", 1'b0, 8'h00, 2'd0, 3'b000, 1'b0);
        applyStimulus(3'b001, {8'h00, 8'h00, 8'h05}, 1'b1);
        checkOutput("t1_cap", 1'b1, 8'h05, 2'd0, 3'b001, 1'b1);
        applyStimulus(3'b001, {8'h00, 8'h00, 8'h06}, 1'b1);
        checkOutput("t1_mask", 1'b0, 8'h05, 2'd0, 3'b000, 1'b1);
        checkOutput("t1_cap2", 1'b1, 8'h06, 2'd0, 3'b001, 1'b1);
        applyStimulus(3'b000, {8'h00, 8'h00, 8'h06}, 1'b1);
        checkOutput("t1_idle", 1'b0, 8'h06, 2'd0, 3'b000, 1'b0);

        // All three producers continuously: one byte per cycle in order 0,1,2
        doReset();
        applyStimulus(3'b111, {8'h30, 8'h20, 8'h10}, 1'b1);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("t2_%0d", k), 1'b1, t2_data[k % 3], IW'(k % 3),
                        NP'(1 << (k % 3)), 1'b1);
        applyStimulus(3'b000, '0, 1'b1);

        // Backpressure holds the first byte with no acks, then resumes in order
        doReset();
        applyStimulus(3'b110, {8'h42, 8'h41, 8'h00}, 1'b0);
        checkOutput("t3_cap", 1'b1, 8'h41, 2'd1, 3'b010, 1'b1);
        applyStimulus(3'b100, {8'h42, 8'h41, 8'h00}, 1'b0);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("t3_hold%0d", k), 1'b1, 8'h41, 2'd1, 3'b000, 1'b1);
        applyStimulus(3'b100, {8'h42, 8'h41, 8'h00}, 1'b1);
        checkOutput("t3_resume", 1'b1, 8'h42, 2'd2, 3'b100, 1'b1);
        applyStimulus(3'b000, '0, 1'b1);
        checkOutput("t3_drain", 1'b0, 8'h42, 2'd2, 3'b000, 1'b0);

        // Producer 2 aborts while the register is full and stalled
        doReset();
        applyStimulus(3'b001, {8'h00, 8'h00, 8'h11}, 1'b0);
        checkOutput("t4_cap", 1'b1, 8'h11, 2'd0, 3'b001, 1'b1);
        applyStimulus(3'b110, {8'h77, 8'h55, 8'h11}, 1'b0);
        checkOutput("t4_hold", 1'b1, 8'h11, 2'd0, 3'b000, 1'b1);
        applyStimulus(3'b010, {8'h77, 8'h55, 8'h11}, 1'b0);
        checkOutput("t4_abort", 1'b1, 8'h11, 2'd0, 3'b000, 1'b1);
        applyStimulus(3'b010, {8'h77, 8'h55, 8'h11}, 1'b1);
        checkOutput("t4_p1", 1'b1, 8'h55, 2'd1, 3'b010, 1'b1);
        applyStimulus(3'b000, '0, 1'b1);
        checkOutput("t4_end", 1'b0, 8'h55, 2'd1, 3'b000, 1'b0);

        // Asynchronous reset while full, then producer 0 has priority again
        doReset();
        applyStimulus(3'b001, {8'h00, 8'h00, 8'h2A}, 1'b0);
        checkOutput("t5_full", 1'b1, 8'h2A, 2'd0, 3'b001, 1'b1);
        applyStimulus(3'b000, {8'h00, 8'h00, 8'h2A}, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        checkNow("t5_async", 1'b0, 8'h00, 2'd0, 3'b000, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(3'b111, {8'h03, 8'h02, 8'h01}, 1'b1);
        checkOutput("t5_prio", 1'b1, 8'h01, 2'd0, 3'b001, 1'b1);
        applyStimulus(3'b000, '0, 1'b1);

        // Randomized traffic: producer 0 always requesting, 1 and 2 occasionally
        doReset();
        rq = '0;
        dt = '0;
        repeat (2000) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (prod_ack[i]) begin
                    rq[i] = (i == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
                    dt[i*DW +: DW] = DW'($urandom);
                end else if (rq[i]) begin
                    if ((i != 0) && ($urandom_range(0, 31) == 0)) rq[i] = 1'b0;
                end else if ((i == 0) || ($urandom_range(0, 7) == 0)) begin
                    rq[i] = 1'b1;
                    dt[i*DW +: DW] = DW'($urandom);
                end
            end
            prod_req   = rq;
            prod_data  = dt;
            cons_ready = ($urandom_range(0, 3) != 0);
        end
        applyStimulus(3'b000, '0, 1'b1);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/shared_byte_arbiter.md
Name: shared_byte_arbiter

Overview:
- Clocked arbiter that shares one byte-wide channel between NUM_PROD producers and a single consumer.
- Replaces the ad-hoc toggle-event handshake with a registered req/ack handshake on the producer side and a valid/ready handshake on the consumer side.
- Fair round-robin selection; a one-entry output register holds the granted byte until the consumer takes it.
- Sits between producer stimulus blocks and the consumer in the interthread-communication examples.

Parameters:
- NUM_PROD, 3, number of requesting producers (2..8).
- DATA_W, 8, width of the shared data word.
- ID_W, $clog2(NUM_PROD), width of the grant index. Derived; never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- prod_req  input  NUM_PROD  per-producer request. Held high with data stable until ack.
- prod_data  input  NUM_PROD*DATA_W  per-producer data. Producer i occupies bits [i*DATA_W +: DATA_W].
- prod_ack  output  NUM_PROD  one-cycle pulse telling producer i its byte was captured.
- cons_valid  output  1  output register holds a byte for the consumer.
- cons_data  output  DATA_W  byte offered to the consumer.
- cons_ready  input  1  consumer accepts cons_data this cycle.
- grant_id  output  ID_W  index of the producer whose byte is in the output register.
- busy  output  1  high whenever cons_valid is high or any unmasked request is pending.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low. All state clears immediately on reset_n low.
- Reset values:
  - cons_valid=0, cons_data=0, grant_id=0, prod_ack=0, busy=0.
  - Round-robin pointer last=NUM_PROD-1, so producer 0 has first priority after reset.
  - FSM in EMPTY.
- FSM states:
  - EMPTY: output register free.
  - FULL: cons_valid=1, waiting for cons_ready.
- Eligible set: prod_req & ~prod_ack. A producer is masked during the cycle its ack is high, so its stale request is never recaptured.
- Selection: the first eligible index searching cyclically from last+1 to last+NUM_PROD (pure combinational priority rotation).
- Capture occurs on a clock edge when either:
  - state is EMPTY and the eligible set is non-empty, or
  - state is FULL, cons_ready=1 and the eligible set is non-empty.
- Actions at a capture edge (winner w):
  - cons_data <= prod_data[w], grant_id <= w, last <= w, cons_valid <= 1, state -> FULL.
  - prod_ack[w] is high for exactly the following cycle.
- Latency: request to capture is 1 edge when the register is free; request to ack visible is 1 cycle.
- Back-to-back transfers:
  - In FULL with cons_ready=1, the consumer handshake and the next capture happen on the same edge.
  - Sustained throughput is one byte per cycle when two or more producers alternate.
  - A single producer alone achieves one byte per two cycles, because of the ack-cycle mask.
- FULL with cons_ready=1 and no eligible request: cons_valid <= 0, state -> EMPTY. cons_data and grant_id hold their last values.
- FULL with cons_ready=0: cons_data, grant_id and cons_valid hold; no capture; no ack.
- cons_ready while EMPTY: ignored.
- Fairness: any continuously requesting producer is captured within NUM_PROD captures.
- Dropping a request before ack is allowed (abort). If the drop occurs before the capture edge, nothing is captured for that producer.
- prod_data for an unrequested producer is don't-care.
- Reset mid-transfer: any held byte is discarded and not delivered; no ack is issued for it after reset.
- prod_ack is one-hot or zero at all times.

Decomposition:
- Package shared_byte_pkg holds:
  - the state enum typedef, arb_state_e {EMPTY, FULL};
  - the DATA_W default constant;
  - a function rr_pick(req, last) returning the winner index and a found flag.
- Natural sub-module: rr_select (combinational rotate-priority picker, NUM_PROD parameter). It is reused by later multi-consumer variants.

Test Plan:
- Reset then single producer: producer 0 reqs 8'h05 with cons_ready=1.
  - Capture on edge 1; prod_ack=3'b001 in cycle 2; cons_valid=1, cons_data=5, grant_id=0.
  - Next byte 8'h06 is captured no earlier than the edge after the ack cycle.
- All three producers request continuously (data 8'h10/20/30) with cons_ready=1 → consumer sees 10,20,30,10,20,30 at 1 byte per cycle; grant_id order 0,1,2,0,1,2.
- Backpressure: cons_ready=0 for 5 cycles while producers 1 and 2 request → cons_data holds the first captured byte; no prod_ack pulses; on ready, delivery resumes in round-robin order.
- Abort: producer 2 raises req then drops it while the register is FULL and cons_ready=0 → producer 2 is never acked or delivered; the remaining producers are unaffected.
- reset_n asserted low while FULL holding 8'h2A → asynchronous clear: cons_valid=0, prod_ack=0 without waiting for clk; after release, producer 0 has priority.
- Fairness: producer 0 requests every cycle while producers 1 and 2 request occasionally → each requesting producer is captured within 3 captures.
